// File: rtl/game_controller.sv
// Game-flow controller: button synchroniser + debouncer, START/PLAY/OVER
// sequencing, and single-cycle event pulses for the VGA overlay chain.
module game_controller #(
    parameter int DEBOUNCE_MS  = 20,
    parameter int OVER_HOLD_MS = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_ms_tick,
    input  logic       btn_raw,
    input  logic       elapsed,
    input  logic       landed,
    input  logic       fell,
    output logic       start_screen_en,
    output logic       time_bar_en,
    output logic       time_bar_start,
    output logic       points_en,
    output logic       points_increase,
    output logic       points_clear,
    output logic       jump,
    output logic       game_over,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_PLAY  = 2'b01,
        ST_OVER  = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    localparam logic [15:0] DB_MAX   = 16'(DEBOUNCE_MS);
    localparam logic [15:0] HOLD_MAX = 16'(OVER_HOLD_MS);

    logic        sync1_q, sync2_q;
    logic [15:0] db_cnt_q, db_cnt_d;
    logic        db_lvl_q, db_lvl_d;
    logic        btn_press_q, btn_press_d;
    logic [15:0] hold_q, hold_d;
    state_t      state_q, state_d;

    logic start_screen_en_q, start_screen_en_d;
    logic time_bar_en_q, time_bar_en_d;
    logic time_bar_start_q, time_bar_start_d;
    logic points_en_q, points_en_d;
    logic points_increase_q, points_increase_d;
    logic points_clear_q, points_clear_d;
    logic jump_q, jump_d;
    logic game_over_q, game_over_d;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a changed level must survive DEBOUNCE_MS ticks; emit rising-edge press.
    always_comb begin
        db_cnt_d = db_cnt_q;
        db_lvl_d = db_lvl_q;
        if (sync2_q == db_lvl_q) begin
            db_cnt_d = 16'd0;
        end else if (one_ms_tick) begin
            if (db_cnt_q + 16'd1 >= DB_MAX) begin
                db_lvl_d = sync2_q;
                db_cnt_d = 16'd0;
            end else begin
                db_cnt_d = db_cnt_q + 16'd1;
            end
        end
        btn_press_d = db_lvl_d & ~db_lvl_q;
    end

    // Next state and registered outputs; OVER entry beats landed/press in PLAY.
    always_comb begin
        state_d           = state_q;
        hold_d            = 16'd0;
        time_bar_start_d  = 1'b0;
        points_increase_d = 1'b0;
        points_clear_d    = 1'b0;
        jump_d            = 1'b0;
        case (state_q)
            ST_START: begin
                if (btn_press_q) begin
                    state_d          = ST_PLAY;
                    points_clear_d   = 1'b1;
                    time_bar_start_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (elapsed || fell) begin
                    state_d = ST_OVER;
                end else begin
                    jump_d = btn_press_q;
                    if (landed) begin
                        points_increase_d = 1'b1;
                        time_bar_start_d  = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                hold_d = hold_q;
                if (one_ms_tick && hold_q < HOLD_MAX) hold_d = hold_q + 16'd1;
                // Early presses are simply dropped, never remembered.
                if (btn_press_q && hold_q == HOLD_MAX) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase
        start_screen_en_d = (state_d == ST_START);
        time_bar_en_d     = (state_d == ST_PLAY);
        points_en_d       = (state_d == ST_PLAY) || (state_d == ST_OVER);
        game_over_d       = (state_d == ST_OVER);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt_q          <= 16'd0;
            db_lvl_q          <= 1'b0;
            btn_press_q       <= 1'b0;
            hold_q            <= 16'd0;
            state_q           <= ST_START;
            start_screen_en_q <= 1'b1;
            time_bar_en_q     <= 1'b0;
            time_bar_start_q  <= 1'b0;
            points_en_q       <= 1'b0;
            points_increase_q <= 1'b0;
            points_clear_q    <= 1'b0;
            jump_q            <= 1'b0;
            game_over_q       <= 1'b0;
        end else begin
            db_cnt_q          <= db_cnt_d;
            db_lvl_q          <= db_lvl_d;
            btn_press_q       <= btn_press_d;
            hold_q            <= hold_d;
            state_q           <= state_d;
            start_screen_en_q <= start_screen_en_d;
            time_bar_en_q     <= time_bar_en_d;
            time_bar_start_q  <= time_bar_start_d;
            points_en_q       <= points_en_d;
            points_increase_q <= points_increase_d;
            points_clear_q    <= points_clear_d;
            jump_q            <= jump_d;
            game_over_q       <= game_over_d;
        end
    end

    assign start_screen_en = start_screen_en_q;
    assign time_bar_en     = time_bar_en_q;
    assign time_bar_start  = time_bar_start_q;
    assign points_en       = points_en_q;
    assign points_increase = points_increase_q;
    assign points_clear    = points_clear_q;
    assign jump            = jump_q;
    assign game_over       = game_over_q;
    assign state           = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with DEBOUNCE_MS=3, OVER_HOLD_MS=5,
// one_ms_tick every 10 clk.
module tb_game_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       one_ms_tick = 1'b0;
    logic       btn_raw = 1'b0;
    logic       elapsed = 1'b0;
    logic       landed = 1'b0;
    logic       fell = 1'b0;
    logic       start_screen_en, time_bar_en, time_bar_start, points_en;
    logic       points_increase, points_clear, jump, game_over;
    logic [1:0] state;

    int checks = 0;
    int fails  = 0;

    // High-cycle counters for each pulse output
    int n_clear = 0, n_tbs = 0, n_inc = 0, n_jump = 0;

    game_controller #(.DEBOUNCE_MS(3), .OVER_HOLD_MS(5)) dut (
        .clk(clk), .rst(rst), .one_ms_tick(one_ms_tick), .btn_raw(btn_raw),
        .elapsed(elapsed), .landed(landed), .fell(fell),
        .start_screen_en(start_screen_en), .time_bar_en(time_bar_en),
        .time_bar_start(time_bar_start), .points_en(points_en),
        .points_increase(points_increase), .points_clear(points_clear),
        .jump(jump), .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (9) @(negedge clk);
            one_ms_tick = 1'b1;
            @(negedge clk);
            one_ms_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (points_clear    === 1'b1) n_clear <= n_clear + 1;
        if (time_bar_start  === 1'b1) n_tbs   <= n_tbs + 1;
        if (points_increase === 1'b1) n_inc   <= n_inc + 1;
        if (jump            === 1'b1) n_jump  <= n_jump + 1;
    end

    function automatic logic [9:0] outv();
        return {state, start_screen_en, time_bar_en, time_bar_start, points_en,
                points_increase, points_clear, jump, game_over};
    endfunction

    localparam logic [9:0] RESET_V = 10'b00_1000_0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (outv() !== RESET_V) begin
            fails++;
            $display("FAIL reset_hold: got %b expected %b", outv(), RESET_V);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (outv() !== RESET_V) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_idle: %0d bad cycles, last %b expected %b", bad, outv(), RESET_V);
        end
    endtask

    task automatic test_bounce_and_start();
        int c0, t0, k;
        c0 = n_clear;
        t0 = n_tbs;
        @(negedge clk) btn_raw = 1'b1;
        repeat (15) @(negedge clk);
        btn_raw = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (state !== 2'b00 || n_clear != c0) begin
            fails++;
            $display("FAIL glitch_reject: state %b clears %0d expected 00 and %0d", state, n_clear, c0);
        end
        btn_raw = 1'b1;
        k = 0;
        while (state !== 2'b01 && k < 200) begin
            step();
            k++;
        end
        checks++;
        if (state !== 2'b01) begin
            fails++;
            $display("FAIL enter_play: state %b expected 01", state);
        end
        checks++;
        if ({points_clear, time_bar_start, time_bar_en, start_screen_en, points_en} !== 5'b11101) begin
            fails++;
            $display("FAIL play_entry_outs: got %b expected 11101",
                     {points_clear, time_bar_start, time_bar_en, start_screen_en, points_en});
        end
        step();
        checks++;
        if ({points_clear, time_bar_start} !== 2'b00) begin
            fails++;
            $display("FAIL entry_pulse_width: got %b expected 00", {points_clear, time_bar_start});
        end
        repeat (60) @(negedge clk);
        btn_raw = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (n_clear - c0 != 1 || n_tbs - t0 != 1 || state !== 2'b01) begin
            fails++;
            $display("FAIL entry_pulse_count: clear %0d tbs %0d state %b expected 1 1 01",
                     n_clear - c0, n_tbs - t0, state);
        end
    endtask

    task automatic test_landed_and_jump();
        int i0, t0, j0;
        i0 = n_inc;
        t0 = n_tbs;
        j0 = n_jump;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk) landed = 1'b1;
            step();
            checks++;
            if ({points_increase, time_bar_start} !== 2'b11) begin
                fails++;
                $display("FAIL landed_pulse%0d: got %b expected 11", p, {points_increase, time_bar_start});
            end
            @(negedge clk) landed = 1'b0;
            step();
            checks++;
            if ({points_increase, time_bar_start} !== 2'b00) begin
                fails++;
                $display("FAIL landed_width%0d: got %b expected 00", p, {points_increase, time_bar_start});
            end
            repeat (48) @(negedge clk);
        end
        checks++;
        if (n_inc - i0 != 3 || n_tbs - t0 != 3) begin
            fails++;
            $display("FAIL landed_count: inc %0d tbs %0d expected 3 3", n_inc - i0, n_tbs - t0);
        end
        btn_raw = 1'b1;
        repeat (60) @(negedge clk);
        btn_raw = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (n_jump - j0 != 1 || state !== 2'b01) begin
            fails++;
            $display("FAIL jump_count: jumps %0d state %b expected 1 01", n_jump - j0, state);
        end
    endtask

    task automatic test_over_priority();
        int i0;
        i0 = n_inc;
        @(negedge clk);
        landed  = 1'b1;
        elapsed = 1'b1;
        step();
        checks++;
        if ({state, game_over, points_increase, points_en, time_bar_en} !== 6'b10_1010) begin
            fails++;
            $display("FAIL over_priority: got %b expected 101010",
                     {state, game_over, points_increase, points_en, time_bar_en});
        end
        @(negedge clk);
        landed  = 1'b0;
        elapsed = 1'b0;
        @(negedge clk) fell = 1'b1;
        @(negedge clk) fell = 1'b0;
        step();
        checks++;
        if (state !== 2'b10 || n_inc != i0) begin
            fails++;
            $display("FAIL over_ignore_fell: state %b incs %0d expected 10 %0d", state, n_inc, i0);
        end
    endtask

    task automatic test_over_hold();
        int k;
        // Press lands after ~3 ticks in OVER, below the hold of 5.
        btn_raw = 1'b1;
        repeat (40) @(negedge clk);
        btn_raw = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (state !== 2'b10) begin
            fails++;
            $display("FAIL early_press_ignored: state %b expected 10", state);
        end
        repeat (50) @(negedge clk);
        checks++;
        if (state !== 2'b10 || game_over !== 1'b1) begin
            fails++;
            $display("FAIL press_not_queued: state %b game_over %b expected 10 1", state, game_over);
        end
        btn_raw = 1'b1;
        k = 0;
        while (state !== 2'b00 && k < 200) begin
            step();
            k++;
        end
        checks++;
        if ({state, start_screen_en, game_over, points_en} !== 5'b00100) begin
            fails++;
            $display("FAIL over_to_start: got %b expected 00100",
                     {state, start_screen_en, game_over, points_en});
        end
        @(negedge clk) btn_raw = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int c0, t0, i0, j0, k;
        btn_raw = 1'b1;
        k = 0;
        while (state !== 2'b01 && k < 200) begin
            step();
            k++;
        end
        @(negedge clk) btn_raw = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (state !== 2'b01) begin
            fails++;
            $display("FAIL replay_entry: state %b expected 01", state);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (outv() !== RESET_V) begin
            fails++;
            $display("FAIL async_reset: got %b expected %b", outv(), RESET_V);
        end
        repeat (3) @(negedge clk);
        c0 = n_clear;
        t0 = n_tbs;
        i0 = n_inc;
        j0 = n_jump;
        rst = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (outv() !== RESET_V || n_clear != c0 || n_tbs != t0 || n_inc != i0 || n_jump != j0) begin
            fails++;
            $display("FAIL post_reset_quiet: out %b pulses %0d/%0d/%0d/%0d expected %b 0/0/0/0",
                     outv(), n_clear - c0, n_tbs - t0, n_inc - i0, n_jump - j0, RESET_V);
        end
    endtask

    initial begin
        test_reset();
        test_bounce_and_start();
        test_landed_and_jump();
        test_over_priority();
        test_over_hold();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
